// File: rtl/iterative_array_multiplier_pkg.sv
// Shared types and helpers for the iterative array multiplier.
package iterative_array_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    DONE     = 2'd2
  } mult_state_t;

  // Iteration counter width, never narrower than one bit.
  function automatic int cnt_width(input int iters);
    if (iters > 1) begin
      return $clog2(iters);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/iterative_array_multiplier_stage.sv
// Combinational array-multiplier stage: adds PRODUCT_PER_STAGE partial-product rows
// of operand_a onto the running {carry, partial} accumulator.
module pipelined_array_multiplier_stage #(
  parameter int DATA_WIDTH        = 8,
  parameter int PRODUCT_PER_STAGE = 4
) (
  input  logic [DATA_WIDTH-1:0]        operand_a,
  input  logic [PRODUCT_PER_STAGE-1:0] operand_b,
  input  logic [DATA_WIDTH-2:0]        partial_in,
  input  logic                         carry_in,
  output logic [DATA_WIDTH-2:0]        partial_product,
  output logic                         carry,
  output logic [PRODUCT_PER_STAGE-1:0] result_bits
);

  localparam int SUM_W = DATA_WIDTH + PRODUCT_PER_STAGE;

  logic [SUM_W-1:0] sum_s;

  // Ripple the selected multiplicand rows into the accumulator; the sum always fits SUM_W bits.
  always_comb begin
    sum_s = {{PRODUCT_PER_STAGE{1'b0}}, carry_in, partial_in};
    for (int row = 0; row < PRODUCT_PER_STAGE; row++) begin
      sum_s = sum_s + (({{PRODUCT_PER_STAGE{1'b0}}, operand_a} & {SUM_W{operand_b[row]}}) << row);
    end
  end

  assign result_bits     = sum_s[PRODUCT_PER_STAGE-1:0];
  assign partial_product = sum_s[SUM_W-2:PRODUCT_PER_STAGE];
  assign carry           = sum_s[SUM_W-1];

endmodule

// File: rtl/iterative_array_multiplier.sv
// Iterative unsigned multiplier reusing one array stage for DATA_WIDTH/PRODUCT_PER_STAGE cycles.
// Optional feature: ITERATIVE_ARRAY_MULTIPLIER_ZERO_SKIP_EN finishes zero-operand products at once.
module iterative_array_multiplier
  import iterative_array_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int PRODUCT_PER_STAGE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [DATA_WIDTH-1:0]   operand_A_i,
  input  logic [DATA_WIDTH-1:0]   operand_B_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int ITERATIONS = DATA_WIDTH / PRODUCT_PER_STAGE;
  localparam int CNT_W      = cnt_width(ITERATIONS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  mult_state_t                  state_r;
  mult_state_t                  state_nxt_s;
  logic [DATA_WIDTH-1:0]        a_r;
  logic [DATA_WIDTH-1:0]        b_r;
  logic [DATA_WIDTH-2:0]        partial_r;
  logic                         carry_r;
  logic [DATA_WIDTH-1:0]        low_r;
  logic [CNT_W-1:0]             cnt_r;
  logic                         accept_s;
  logic                         zero_s;
  logic [DATA_WIDTH-2:0]        stage_partial_s;
  logic                         stage_carry_s;
  logic [PRODUCT_PER_STAGE-1:0] stage_bits_s;
  logic [DATA_WIDTH-1:0]        low_nxt_s;

  assign accept_s = valid_i & ready_o;

`ifdef ITERATIVE_ARRAY_MULTIPLIER_ZERO_SKIP_EN
  assign zero_s = (operand_A_i == {DATA_WIDTH{1'b0}}) | (operand_B_i == {DATA_WIDTH{1'b0}});
`else
  assign zero_s = 1'b0;
`endif

  pipelined_array_multiplier_stage #(
    .DATA_WIDTH       (DATA_WIDTH),
    .PRODUCT_PER_STAGE(PRODUCT_PER_STAGE)
  ) u_stage (
    .operand_a      (a_r),
    .operand_b      (b_r[PRODUCT_PER_STAGE-1:0]),
    .partial_in     (partial_r),
    .carry_in       (carry_r),
    .partial_product(stage_partial_s),
    .carry          (stage_carry_s),
    .result_bits    (stage_bits_s)
  );

  // Finished low-order bits enter at the top and migrate down one stage width per iteration.
  generate
    if (PRODUCT_PER_STAGE == DATA_WIDTH) begin : g_single_iter
      assign low_nxt_s = stage_bits_s;
    end else begin : g_multi_iter
      assign low_nxt_s = {stage_bits_s, low_r[DATA_WIDTH-1:PRODUCT_PER_STAGE]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a zero operand may bypass the iterations entirely.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = zero_s ? DONE : MULTIPLY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MULTIPLY: begin
        if (cnt_r == LAST_ITER) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MULTIPLY;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nxt_s = zero_s ? DONE : MULTIPLY;
        end else if (ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the registered state; in DONE the next operands ride on the consumer's ready.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    case (state_r)
      IDLE:     ready_o = 1'b1;
      MULTIPLY: busy_o  = 1'b1;
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
      end
      default: ready_o = 1'b0;
    endcase
  end

  // Operand, accumulator and iteration registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_r       <= {DATA_WIDTH{1'b0}};
      b_r       <= {DATA_WIDTH{1'b0}};
      partial_r <= {(DATA_WIDTH-1){1'b0}};
      carry_r   <= 1'b0;
      low_r     <= {DATA_WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_r       <= zero_s ? {DATA_WIDTH{1'b0}} : operand_A_i;
      b_r       <= zero_s ? {DATA_WIDTH{1'b0}} : operand_B_i;
      partial_r <= {(DATA_WIDTH-1){1'b0}};
      carry_r   <= 1'b0;
      low_r     <= {DATA_WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (state_r == MULTIPLY) begin
      partial_r <= stage_partial_s;
      carry_r   <= stage_carry_s;
      low_r     <= low_nxt_s;
      b_r       <= b_r >> PRODUCT_PER_STAGE;
      cnt_r     <= cnt_r + CNT_W'(1);
    end
  end

  assign product_o = {carry_r, partial_r, low_r};

endmodule
